// File: rtl/hrm_pkg.sv
// Shared constants for the HRM CPU inbox/outbox byte FIFOs.
package hrm_pkg;

    // Byte-wide datapath of the HRM CPU.
    localparam int HRM_DATA_W = 8;

    // Default pointer width of the OUTBOX FIFO (16 entries).
    localparam int OUTBOX_ADDR_W = 4;

    typedef logic [HRM_DATA_W-1:0] hrm_byte_t;

    // Number of entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/hrm_outbox_if.sv
// Push/pop/status bundle between the CPU core, the outbox FIFO and its reader.
interface hrm_outbox_if
    import hrm_pkg::*;
#(
    parameter int ADDR_W = OUTBOX_ADDR_W,
    parameter int DATA_W = HRM_DATA_W
);
    logic              clr;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              rd;
    logic              empty;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    // Environment side: the CPU core pushing and the external reader popping.
    modport master (
        output clr, wr, data_in, rd,
        input  full, empty, data_out, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  clr, wr, data_in, rd,
        output full, empty, data_out, count, overflow, underflow
    );
endinterface

// File: rtl/hrm_fifo_ctrl.sv
// Pointer, occupancy, full/empty and sticky error-flag control for the outbox FIFO.
module hrm_fifo_ctrl
    import hrm_pkg::*;
#(
    parameter int ADDR_W = OUTBOX_ADDR_W
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    output logic              we,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    logic            do_rd;
    logic            do_wr;
    logic [ADDR_W:0] count_next;

    // A pop needs data; a push needs room, or a pop freeing a slot in the same cycle.
    always_comb begin
        do_rd = rd && !empty;
        do_wr = wr && (!full || do_rd);
        we    = do_wr && !clr;
    end

    // Next occupancy: simultaneous accepted push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + (ADDR_W+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count - (ADDR_W+1)'(1);
        end
    end

    // Pointer/count/flag state; clr flushes ahead of any push or pop.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == '0);
            if (wr && !do_wr) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hrm_outbox.sv
// CPU OUTBOX: first-word-fall-through byte FIFO with occupancy and sticky error flags.
module hrm_outbox
    import hrm_pkg::*;
#(
    parameter int ADDR_W = OUTBOX_ADDR_W,
    parameter int DATA_W = HRM_DATA_W
) (
    input  logic         clk,
    input  logic         i_rst,
    hrm_outbox_if.slave  bus
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic              we;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    hrm_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk       (clk),
        .i_rst     (i_rst),
        .clr       (bus.clr),
        .wr        (bus.wr),
        .rd        (bus.rd),
        .we        (we),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (bus.count),
        .full      (bus.full),
        .empty     (bus.empty),
        .overflow  (bus.overflow),
        .underflow (bus.underflow)
    );

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Head entry falls through; zero when empty so the output never shows stale data.
    always_comb begin
        bus.data_out = bus.empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_hrm_outbox.sv
// Directed scoreboard bench for the hrm_outbox FIFO.
module tb_hrm_outbox;

    logic clk = 1'b0;
    logic i_rst;

    hrm_outbox_if bus ();

    hrm_outbox dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (!i_rst && bus.rd && !bus.empty) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_data: got 0x%0h, expected no data", bus.data_out);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (bus.data_out !== exp) begin
                    miscompares++;
                    $display("FAIL pop_data: got 0x%0h, expected 0x%0h", bus.data_out, exp);
                end
            end
        end
    end

    // Apply one cycle of stimulus; acc marks a push the FIFO must accept.
    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit acc);
        bus.wr      = w;
        bus.data_in = d;
        bus.rd      = r;
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        idle();
        bus.clr = 1'b0;
    endtask

    task automatic check_empty_state(input string tag);
        check({tag, "_count"},    32'(bus.count), 32'd0);
        check({tag, "_empty"},    32'(bus.empty), 32'd1);
        check({tag, "_full"},     32'(bus.full), 32'd0);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        i_rst       = 1'b1;
        bus.clr     = 1'b0;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.data_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        idle();

        // Reset state
        check_empty_state("reset");
        check("reset_overflow",  32'(bus.overflow), 32'd0);
        check("reset_underflow", 32'(bus.underflow), 32'd0);

        // Three pushes, empty falls right after the first edge, then three pops
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        check("first_push_empty", 32'(bus.empty), 32'd0);
        check("first_push_head",  32'(bus.data_out), 32'h11);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        check("three_count", 32'(bus.count), 32'd3);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        check_empty_state("three_drained");

        // Fill to 16, overflow on the 17th, drain in order
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
        check("fill_full",  32'(bus.full), 32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_empty", 32'(bus.empty), 32'd0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_flag",  32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        check_empty_state("fill_drained");
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        do_clr();
        check("clr_overflow", 32'(bus.overflow), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
        drive(1'b1, 8'h55, 1'b1, 1'b1);
        check("full_rw_count",    32'(bus.count), 32'd16);
        check("full_rw_overflow", 32'(bus.overflow), 32'd0);
        check("full_rw_full",     32'(bus.full), 32'd1);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        check_empty_state("full_rw_drained");

        // Underflow, then push+pop on empty
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_flag",  32'(bus.underflow), 32'd1);
        check("udf_count", 32'(bus.count), 32'd0);
        drive(1'b1, 8'h7E, 1'b1, 1'b1);
        check("empty_rw_count", 32'(bus.count), 32'd1);
        check("empty_rw_head",  32'(bus.data_out), 32'h7E);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        do_clr();
        check("clr_underflow", 32'(bus.underflow), 32'd0);
        check_empty_state("clr");

        // Back-to-back streaming reader; pointers wrap more than twice
        for (int i = 0; i < 40; i++) drive(1'b1, 8'(8'hA0 + i), (i > 0), 1'b1);
        check("stream_count", 32'(bus.count), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        // Alternate-cycle reader
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
            else            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        idle();
        check_empty_state("stream_drained");
        check("stream_overflow",  32'(bus.overflow), 32'd0);
        check("stream_underflow", 32'(bus.underflow), 32'd0);

        // Async reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
        bus.wr = 1'b0;
        check("pre_rst_count", 32'(bus.count), 32'd5);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_empty", 32'(bus.empty), 32'd1);
        check("async_rst_count", 32'(bus.count), 32'd0);
        check("async_rst_data",  32'(bus.data_out), 32'h0);
        sb.delete();
        #2;
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 8'h42, 1'b0, 1'b1);
        check("post_rst_head", 32'(bus.data_out), 32'h42);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        idle();
        check_empty_state("final");
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
